// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM capture block and its input front-end.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pwmState_e;

  localparam int unsigned DEFAULT_CNT_W   = 32;
  localparam logic [31:0] DEFAULT_TIMEOUT = 32'h00FF_FFFF;

endpackage

// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM source/consumer and the capture block.
interface pwm_capture_if
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = DEFAULT_CNT_W
);

  logic             pwm_in;
  logic             enable;
  logic [CNT_W-1:0] high_count;
  logic [CNT_W-1:0] period_count;
  logic             meas_valid;
  logic             timeout;
  logic             signal_lost;
  logic             stuck_level;

  modport master (
    output pwm_in,
    output enable,
    input  high_count,
    input  period_count,
    input  meas_valid,
    input  timeout,
    input  signal_lost,
    input  stuck_level
  );

  modport slave (
    input  pwm_in,
    input  enable,
    output high_count,
    output period_count,
    output meas_valid,
    output timeout,
    output signal_lost,
    output stuck_level
  );

endinterface

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer for an asynchronous input plus single-cycle rise/fall detection.
module pwm_sync_edge (
  input  logic clock,
  input  logic reset_n,
  input  logic async_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic syncDly_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q    <= 1'b0;
      sync_q    <= 1'b0;
      syncDly_q <= 1'b0;
    end else begin
      meta_q    <= async_i;
      sync_q    <= meta_q;
      syncDly_q <= sync_q;
    end
  end

  assign s_o    = sync_q;
  assign rise_o = sync_q & ~syncDly_q;
  assign fall_o = ~sync_q & syncDly_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of a PWM input in clock cycles, with a
// no-edge watchdog that reports a lost or stuck input.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned      CNT_W   = DEFAULT_CNT_W,
  parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(DEFAULT_TIMEOUT)
) (
  input logic          clock,
  input logic          reset_n,
  pwm_capture_if.slave bus
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic s;
  logic rise;
  logic fall;

  pwm_sync_edge u_sync_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .async_i (bus.pwm_in),
    .s_o     (s),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  pwmState_e        state_q,       state_d;
  logic [CNT_W-1:0] hiCnt_q,       hiCnt_d;
  logic [CNT_W-1:0] perCnt_q,      perCnt_d;
  logic [CNT_W-1:0] edgeCnt_q,     edgeCnt_d;
  logic [CNT_W-1:0] highCount_q,   highCount_d;
  logic [CNT_W-1:0] periodCount_q, periodCount_d;
  logic             measValid_q,   measValid_d;
  logic             timeout_q,     timeout_d;
  logic             signalLost_q,  signalLost_d;
  logic             stuckLevel_q,  stuckLevel_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      hiCnt_q       <= '0;
      perCnt_q      <= '0;
      edgeCnt_q     <= '0;
      highCount_q   <= '0;
      periodCount_q <= '0;
      measValid_q   <= 1'b0;
      timeout_q     <= 1'b0;
      signalLost_q  <= 1'b0;
      stuckLevel_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      hiCnt_q       <= hiCnt_d;
      perCnt_q      <= perCnt_d;
      edgeCnt_q     <= edgeCnt_d;
      highCount_q   <= highCount_d;
      periodCount_q <= periodCount_d;
      measValid_q   <= measValid_d;
      timeout_q     <= timeout_d;
      signalLost_q  <= signalLost_d;
      stuckLevel_q  <= stuckLevel_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    hiCnt_d       = hiCnt_q;
    perCnt_d      = perCnt_q;
    edgeCnt_d     = edgeCnt_q;
    highCount_d   = highCount_q;
    periodCount_d = periodCount_q;
    measValid_d   = 1'b0;
    timeout_d     = 1'b0;
    signalLost_d  = signalLost_q;
    stuckLevel_d  = stuckLevel_q;

    if (!bus.enable) begin
      // Drop any partial period so re-enable always measures rise-to-rise.
      state_d   = IDLE;
      hiCnt_d   = '0;
      perCnt_d  = '0;
      edgeCnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            hiCnt_d  = ONE;
            perCnt_d = ONE;
            state_d  = HIGH;
          end
        end
        HIGH: begin
          perCnt_d = perCnt_q + ONE;
          if (fall) begin
            state_d = LOW;
          end else begin
            hiCnt_d = hiCnt_q + ONE;
          end
        end
        LOW: begin
          if (rise) begin
            highCount_d   = hiCnt_q;
            periodCount_d = perCnt_q;
            measValid_d   = 1'b1;
            hiCnt_d       = ONE;
            perCnt_d      = ONE;
            state_d       = HIGH;
          end else begin
            perCnt_d = perCnt_q + ONE;
          end
        end
        default: begin
          state_d  = IDLE;
          hiCnt_d  = '0;
          perCnt_d = '0;
        end
      endcase

      // An edge always beats the watchdog, so timeout never coincides with a strobe.
      if (rise || fall) begin
        edgeCnt_d    = '0;
        signalLost_d = 1'b0;
      end else if (edgeCnt_q != TIMEOUT) begin
        edgeCnt_d = edgeCnt_q + ONE;
        if (edgeCnt_d == TIMEOUT) begin
          timeout_d    = 1'b1;
          signalLost_d = 1'b1;
          stuckLevel_d = s;
          state_d      = IDLE;
          hiCnt_d      = '0;
          perCnt_d     = '0;
        end
      end
    end
  end

  assign bus.high_count   = highCount_q;
  assign bus.period_count = periodCount_q;
  assign bus.meas_valid   = measValid_q;
  assign bus.timeout      = timeout_q;
  assign bus.signal_lost  = signalLost_q;
  assign bus.stuck_level  = stuckLevel_q;

endmodule
